// File: rtl/hasti_sram_bridge.sv
// AHB-lite (HASTI) slave mapping an aligned address window onto a single-port synchronous SRAM.
// Inserts wait states for SRAM read latency and write/read port collisions; illegal accesses get ERROR.
module hasti_sram_bridge #(
    parameter int unsigned            ADDR_WIDTH   = 32,
    parameter int unsigned            MEM_AW       = 10,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = '0,
    parameter int unsigned            READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic                  hmastlock,
    input  logic [31:0]           hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [31:0]           hrdata,
    output logic [MEM_AW-1:0]     sram_address,
    output logic [3:0]            sram_byteena,
    output logic [31:0]           sram_data,
    output logic                  sram_wren,
    input  logic [31:0]           sram_q
);

    localparam int unsigned TAG_LSB  = MEM_AW + 2;
    localparam logic [1:0]  CNT_INIT = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RDD,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e            state_q, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [MEM_AW-1:0] sram_address_q;
    logic [3:0]        sram_byteena_q;
    logic [31:0]       sram_data_q;

    logic rd_done, slot_free, accept, legal, align_ok, issue_rd;
    logic unused_ok;

    assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0]};

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    return 4'b0001 << a;
            3'd1:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'hF;
        endcase
    endfunction

    always_comb begin
        case (hsize)
            3'd0:    align_ok = 1'b1;
            3'd1:    align_ok = ~haddr[0];
            3'd2:    align_ok = (haddr[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

    assign legal = (hsize <= 3'd2) && align_ok &&
                   (haddr[ADDR_WIDTH-1:TAG_LSB] == BASE_ADDR[ADDR_WIDTH-1:TAG_LSB]);

    // New transfers are only taken in cycles that end a data phase with hreadyout high.
    assign rd_done   = (state_q == S_RD) && (cnt_q == 2'd0);
    assign slot_free = (state_q == S_IDLE) || (state_q == S_WR) || (state_q == S_ERR2) || rd_done;
    assign accept    = hsel && hready && htrans[1] && slot_free;
    // While WR owns the SRAM port, a read must be deferred to RDD instead.
    assign issue_rd  = accept && legal && !hwrite && (state_q != S_WR);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            be_q           <= '0;
            cnt_q          <= '0;
            sram_address_q <= '0;
            sram_byteena_q <= '0;
            sram_data_q    <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            be_q           <= be_d;
            cnt_q          <= cnt_d;
            sram_address_q <= sram_address;
            sram_byteena_q <= sram_byteena;
            sram_data_q    <= sram_data;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_ERR1: state_d = S_ERR2;
            S_RDD: begin
                state_d = S_RD;
                cnt_d   = CNT_INIT;
            end
            S_RD: begin
                if (cnt_q != 2'd0) cnt_d   = cnt_q - 2'd1;
                else               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            if (!legal) begin
                state_d = S_ERR1;
            end else if (hwrite) begin
                state_d = S_WR;
                addr_d  = haddr[TAG_LSB-1:2];
                be_d    = lane_mask(hsize, haddr[1:0]);
            end else if (state_q == S_WR) begin
                state_d = S_RDD;
                addr_d  = haddr[TAG_LSB-1:2];
            end else begin
                state_d = S_RD;
                cnt_d   = CNT_INIT;
            end
        end
    end

    assign hreadyout = !((state_q == S_RDD) || (state_q == S_ERR1) ||
                         ((state_q == S_RD) && (cnt_q != 2'd0)));
    assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);

    always_comb begin
        hrdata       = '0;
        sram_wren    = 1'b0;
        sram_address = sram_address_q;
        sram_byteena = sram_byteena_q;
        sram_data    = sram_data_q;
        case (state_q)
            S_WR: begin
                sram_wren    = 1'b1;
                sram_address = addr_q;
                sram_byteena = be_q;
                sram_data    = hwdata;
            end
            S_RDD: begin
                sram_address = addr_q;
                sram_byteena = 4'hF;
            end
            S_RD: begin
                if (cnt_q == 2'd0) hrdata = sram_q;
            end
            default: ;
        endcase
        if (issue_rd) begin
            sram_address = haddr[TAG_LSB-1:2];
            sram_byteena = 4'hF;
        end
    end

endmodule
